// File: rtl/fifo_frame_pkg.sv
// Shared types and default widths for the length-framed FIFO reader.
package fifo_frame_pkg;

  localparam int unsigned DEF_DSIZE   = 32;
  localparam int unsigned DEF_LEN_W   = 16;
  localparam int unsigned DEF_ZCNT_W  = 8;
  localparam int unsigned HDR_LEN_LSB = 0;

  typedef enum logic [1:0] {
    S_HDR      = 2'd0,
    S_HDR_WAIT = 2'd1,
    S_PAY      = 2'd2
  } state_t;

  // Routing tag carried alongside each outstanding FIFO pop.
  typedef struct packed {
    logic is_hdr;
    logic is_last;
  } pop_tag_t;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry in-order valid/ready buffer carrying {data, last}.
// The head entry drives the stream outputs directly from flops.
module stream_buf2
  import fifo_frame_pkg::*;
#(
  parameter int unsigned DSIZE = DEF_DSIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             push_last,
  output logic [1:0]       occ,
  output logic [DSIZE-1:0] m_data,
  output logic             m_last,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [DSIZE-1:0] tail_data;
  logic             tail_last;
  logic             drain;
  logic [1:0]       wr_idx;

  assign m_valid = (occ != 2'd0);
  assign drain   = m_valid && m_ready;
  // Slot a new word lands in once this cycle's drain has shifted the tail up.
  assign wr_idx  = occ - 2'(drain);

  always_ff @(posedge clk) begin
    if (rst) begin
      occ       <= 2'd0;
      m_data    <= '0;
      m_last    <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else begin
      if (drain) begin
        m_data <= tail_data;
        m_last <= tail_last;
      end
      if (push) begin
        if (wr_idx == 2'd0) begin
          m_data <= push_data;
          m_last <= push_last;
        end else begin
          tail_data <= push_data;
          tail_last <= push_last;
        end
      end
      occ <= occ + 2'(push) - 2'(drain);
    end
  end

endmodule

// File: rtl/fifo_frame_reader.sv
// Pops length-framed records from a synchronous FIFO and replays the payload
// as a valid/ready stream with a last marker; headers are consumed internally.
module fifo_frame_reader
  import fifo_frame_pkg::*;
#(
  parameter int unsigned DSIZE  = DEF_DSIZE,
  parameter int unsigned LEN_W  = DEF_LEN_W,
  parameter int unsigned ZCNT_W = DEF_ZCNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DSIZE-1:0]  fifo_rdata,
  input  logic              fifo_rempty,
  output logic              fifo_rinc,
  output logic [DSIZE-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic [ZCNT_W-1:0] zlen_cnt
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             inflight_q;
  pop_tag_t         tag_q, tag_d;
  logic             zlen_inc;

  logic [1:0]       occ;
  logic             drain;
  logic [2:0]       pending;
  logic             credit_ok;
  logic             state_allows;
  logic             hdr_cap;
  logic             pay_cap;
  logic [LEN_W-1:0] hdr_len;

  assign hdr_len = fifo_rdata[HDR_LEN_LSB +: LEN_W];
  assign hdr_cap = inflight_q && tag_q.is_hdr;
  assign pay_cap = inflight_q && !tag_q.is_hdr;

  // Credit counts buffered words plus the outstanding pop, less this cycle's drain.
  assign drain     = m_valid && m_ready;
  assign pending   = 3'(occ) + 3'(inflight_q) - 3'(drain);
  assign credit_ok = (pending < 3'd2);

  assign state_allows = (state_q == S_HDR) ||
                        ((state_q == S_PAY) && (rem_q != '0));

  assign fifo_rinc = !rst && !fifo_rempty && state_allows && credit_ok;

  assign busy = (state_q != S_HDR) || (occ != 2'd0) || inflight_q;

  // Next-state, remaining-length and pop-tag decode.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    tag_d    = '0;
    zlen_inc = 1'b0;
    case (state_q)
      S_HDR: begin
        tag_d.is_hdr = 1'b1;
        if (fifo_rinc) state_d = S_HDR_WAIT;
      end
      S_HDR_WAIT: begin
        if (hdr_cap) begin
          if (hdr_len == '0) begin
            zlen_inc = 1'b1;
            state_d  = S_HDR;
          end else begin
            rem_d   = hdr_len;
            state_d = S_PAY;
          end
        end
      end
      S_PAY: begin
        tag_d.is_last = (rem_q == LEN_W'(1));
        if (fifo_rinc) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_HDR;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      zlen_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      inflight_q <= fifo_rinc;
      if (fifo_rinc) tag_q <= tag_d;
      if (zlen_inc && (zlen_cnt != {ZCNT_W{1'b1}})) zlen_cnt <= zlen_cnt + ZCNT_W'(1);
    end
  end

  stream_buf2 #(
    .DSIZE(DSIZE)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (pay_cap),
    .push_data (fifo_rdata),
    .push_last (tag_q.is_last),
    .occ       (occ),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

endmodule
